// File: rtl/pps_gen.sv
// PPS pulse generator: fires pps_out when the rtclock time crosses offset_ns within each second.
// Define PPS_GEN_TOD_EN to add the tod_sec/tod_valid time-of-day outputs.
module pps_gen #(
    parameter int C_CLK_TO_NS_RATIO = 8,
    parameter int C_CNT_WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [29:0]            offset_ns,
    input  logic [29:0]            width_ns,
    input  logic [47:0]            sec,
    input  logic [29:0]            nsec,
    output logic                   pps_out,
    output logic                   armed,
    output logic                   cfg_err,
    output logic [C_CNT_WIDTH-1:0] pulse_cnt,
`ifdef PPS_GEN_TOD_EN
    output logic [47:0]            tod_sec,
    output logic                   tod_valid,
`endif
    output logic [C_CNT_WIDTH-1:0] jump_cnt
);

    localparam int          ACC_W      = 32;
    localparam logic [29:0] NS_PER_SEC = 30'd1_000_000_000;
    localparam logic [29:0] MAX_WIDTH  = 30'd999_999_999;
    localparam logic [ACC_W-1:0] ACC_STEP = ACC_W'(C_CLK_TO_NS_RATIO);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_ARMED    = 2'd2,
        ST_PULSE    = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [ACC_W-1:0]       acc_r;
    logic [ACC_W-1:0]       acc_next_s;
    logic [47:0]            prev_sec_r;
    logic [29:0]            prev_nsec_r;
    logic                   pps_r;
    logic                   armed_r;
    logic                   cfg_err_r;
    logic [C_CNT_WIDTH-1:0] pulse_cnt_r;
    logic [C_CNT_WIDTH-1:0] jump_cnt_r;

    logic                   cfg_bad_s;
    logic [29:0]            width_clamp_s;
    logic [47:0]            sec_inc_s;
    logic                   same_sec_s;
    logic                   next_sec_s;
    logic                   jump_s;
    logic                   cross_s;
    logic                   eval_s;
    logic                   hit_s;
    logic                   jump_hit_s;

    assign cfg_bad_s     = (offset_ns >= NS_PER_SEC);
    assign width_clamp_s = (width_ns > MAX_WIDTH) ? MAX_WIDTH : width_ns;
    assign sec_inc_s     = prev_sec_r + 48'd1;
    assign same_sec_s    = (sec == prev_sec_r);
    assign next_sec_s    = (sec == sec_inc_s);

    // Classify the (prev, current) time pair as a discontinuity or a trigger crossing.
    assign jump_s  = !(same_sec_s || next_sec_s) || (same_sec_s && (nsec < prev_nsec_r));
    assign cross_s = (same_sec_s && (prev_nsec_r < offset_ns) && (nsec >= offset_ns)) ||
                     (next_sec_s && ((prev_nsec_r < offset_ns) || (nsec >= offset_ns)));

    // A bad offset suppresses all evaluation, so no event is counted while cfg_err is set.
    assign eval_s     = enable && !cfg_bad_s &&
                        ((state_r == ST_ARMED) || (state_r == ST_PULSE));
    assign hit_s      = eval_s && !jump_s && cross_s;
    assign jump_hit_s = eval_s && jump_s;

    // Next-state and width accumulator logic.
    always_comb begin
        next_state_s = state_r;
        acc_next_s   = acc_r;
        case (state_r)
            ST_DISABLED: begin
                if (enable) begin
                    next_state_s = ST_SYNC;
                end else begin
                    next_state_s = ST_DISABLED;
                end
            end
            ST_SYNC: begin
                next_state_s = ST_ARMED;
            end
            ST_ARMED: begin
                if (cfg_bad_s || jump_s) begin
                    next_state_s = ST_ARMED;
                end else if (cross_s) begin
                    next_state_s = ST_PULSE;
                    acc_next_s   = ACC_STEP;
                end else begin
                    next_state_s = ST_ARMED;
                end
            end
            ST_PULSE: begin
                if (cfg_bad_s || jump_s) begin
                    next_state_s = ST_ARMED;
                end else if (cross_s) begin
                    next_state_s = ST_PULSE;
                    acc_next_s   = ACC_STEP;
                end else if (acc_r >= ACC_W'(width_clamp_s)) begin
                    next_state_s = ST_ARMED;
                end else begin
                    next_state_s = ST_PULSE;
                    acc_next_s   = acc_r + ACC_STEP;
                end
            end
            default: begin
                next_state_s = ST_DISABLED;
                acc_next_s   = {ACC_W{1'b0}};
            end
        endcase
        if (!enable) begin
            next_state_s = ST_DISABLED;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State, time history, registered outputs and event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_DISABLED;
            acc_r       <= {ACC_W{1'b0}};
            prev_sec_r  <= 48'd0;
            prev_nsec_r <= 30'd0;
            pps_r       <= 1'b0;
            armed_r     <= 1'b0;
            cfg_err_r   <= 1'b0;
            pulse_cnt_r <= {C_CNT_WIDTH{1'b0}};
            jump_cnt_r  <= {C_CNT_WIDTH{1'b0}};
        end else begin
            state_r     <= next_state_s;
            acc_r       <= acc_next_s;
            prev_sec_r  <= sec;
            prev_nsec_r <= nsec;
            pps_r       <= (next_state_s == ST_PULSE);
            armed_r     <= (next_state_s == ST_ARMED) || (next_state_s == ST_PULSE);
            cfg_err_r   <= cfg_bad_s;
            if (hit_s) begin
                pulse_cnt_r <= pulse_cnt_r + C_CNT_WIDTH'(1);
            end
            if (jump_hit_s) begin
                jump_cnt_r <= jump_cnt_r + C_CNT_WIDTH'(1);
            end
        end
    end

    assign pps_out   = pps_r;
    assign armed     = armed_r;
    assign cfg_err   = cfg_err_r;
    assign pulse_cnt = pulse_cnt_r;
    assign jump_cnt  = jump_cnt_r;

`ifdef PPS_GEN_TOD_EN
    logic [47:0] tod_sec_r;
    logic        tod_valid_r;

    // Latch the second holding the trigger point on every accepted crossing.
    always_ff @(posedge clk) begin
        if (reset) begin
            tod_sec_r   <= 48'd0;
            tod_valid_r <= 1'b0;
        end else begin
            tod_valid_r <= hit_s;
            if (hit_s) begin
                tod_sec_r <= (nsec >= offset_ns) ? sec : prev_sec_r;
            end
        end
    end

    assign tod_sec   = tod_sec_r;
    assign tod_valid = tod_valid_r;
`endif

endmodule

// File: tb/tb_pps_gen.sv
// Self-checking bench for pps_gen: vector table, directed corner sequences and random
// time stimulus compared against an interval-based reference model.
module tb_pps_gen;

    localparam longint NS    = 64'd1_000_000_000;
    localparam longint RATIO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [29:0] offset_ns = 30'd0;
    logic [29:0] width_ns = 30'd0;
    logic [47:0] sec = 48'd0;
    logic [29:0] nsec = 30'd0;
    logic        pps_out;
    logic        armed;
    logic        cfg_err;
    logic [31:0] pulse_cnt;
    logic [31:0] jump_cnt;
`ifdef PPS_GEN_TOD_EN
    logic [47:0] tod_sec;
    logic        tod_valid;
`endif

    pps_gen #(.C_CLK_TO_NS_RATIO(8), .C_CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .offset_ns(offset_ns), .width_ns(width_ns), .sec(sec), .nsec(nsec),
        .pps_out(pps_out), .armed(armed), .cfg_err(cfg_err), .pulse_cnt(pulse_cnt),
`ifdef PPS_GEN_TOD_EN
        .tod_sec(tod_sec), .tod_valid(tod_valid),
`endif
        .jump_cnt(jump_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // reference model state: mode 0 = off, 1 = syncing, 2 = active
    int     m_mode;
    longint m_rem;
    longint m_ps, m_pn;
    int unsigned m_pcnt, m_jcnt;
    logic   m_cfg;
    longint m_tod;
    logic   m_tv;

    longint cur_s, cur_n, off_v;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
    endtask

    // Expected effect of one clock edge given the inputs currently applied.
    task automatic model_step();
        longint s, n, off, w, tp, tc, trig;
        bit crossed, jumped, bad;
        s = longint'(sec); n = longint'(nsec);
        off = longint'(offset_ns); w = longint'(width_ns);
        if (w > 999_999_999) w = 999_999_999;
        bad = (off >= NS);
        crossed = 1'b0; jumped = 1'b0;
        if (reset) begin
            m_mode = 0; m_rem = 0; m_pcnt = 0; m_jcnt = 0; m_cfg = 1'b0;
            m_tod = 0; m_tv = 1'b0; m_ps = 0; m_pn = 0;
        end else begin
            tp = m_ps * NS + m_pn;
            tc = s * NS + n;
            if (!enable) begin
                m_mode = 0; m_rem = 0;
            end else if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1) m_mode = 2;
            else if (bad) m_rem = 0;
            else begin
                jumped = !(s == m_ps || s == m_ps + 1) || (tc < tp);
                if (!jumped) begin
                    trig = ((m_pn < off) ? m_ps : m_ps + 1) * NS + off;
                    crossed = (trig <= tc);
                end
                if (jumped) begin
                    m_jcnt++; m_rem = 0;
                end else if (crossed) begin
                    m_pcnt++;
                    m_rem = (w == 0) ? 1 : (w + RATIO - 1) / RATIO;
                    m_tod = (n >= off) ? s : m_ps;
                end else if (m_rem > 0) m_rem--;
            end
            m_tv = crossed;
            m_cfg = bad;
            m_ps = s; m_pn = n;
        end
    endtask

    // Apply one clock and compare every output with the model.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("pps", pps_out, (m_mode == 2 && m_rem > 0));
        chk("armed", armed, (m_mode == 2));
        chk("cfg_err", cfg_err, m_cfg);
        chk("pulse_cnt", pulse_cnt, m_pcnt);
        chk("jump_cnt", jump_cnt, m_jcnt);
`ifdef PPS_GEN_TOD_EN
        chk("tod_sec", tod_sec, m_tod);
        chk("tod_valid", tod_valid, m_tv);
`endif
    endtask

    task automatic set_t(input longint s, input longint n);
        cur_s = s; cur_n = n;
        sec = 48'(s); nsec = 30'(n);
    endtask

    task automatic adv(input longint d);
        cur_n += d;
        if (cur_n >= NS) begin cur_n -= NS; cur_s++; end
        set_t(cur_s, cur_n);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; cyc(); reset = 1'b0;
    endtask

    task automatic rand_time();
        int r;
        r = $urandom_range(0, 99);
        if (r < 2) begin
            if (cur_n >= 200) cur_n -= $urandom_range(1, 200);
        end else if (r < 4) cur_s += $urandom_range(2, 5);
        else if (r < 6) cur_s += 1;
        else if (r < 10) begin
            if (off_v >= 64 && off_v < NS) cur_n = off_v - $urandom_range(0, 64);
            else cur_n = $urandom_range(0, 1000);
        end else if (r < 13) cur_n = 999_999_900 + $urandom_range(0, 99);
        else begin
            cur_n += $urandom_range(0, 24);
            if (cur_n >= NS) begin cur_n -= NS; cur_s++; end
        end
        set_t(cur_s, cur_n);
    endtask

    typedef struct {
        logic   rst;
        logic   en;
        longint s;
        longint n;
        logic   pps;
        logic   arm;
        int     pc;
        int     jc;
    } vec_t;

    vec_t tv[17];

    initial begin
        // offset 500, width 0: single-cycle pulses, jumps, one-second step, retrigger
        tv[0]  = '{1'b1, 1'b0,  3, 472, 1'b0, 1'b0, 0, 0};
        tv[1]  = '{1'b0, 1'b1,  3, 480, 1'b0, 1'b0, 0, 0};
        tv[2]  = '{1'b0, 1'b1,  3, 488, 1'b0, 1'b1, 0, 0};
        tv[3]  = '{1'b0, 1'b1,  3, 496, 1'b0, 1'b1, 0, 0};
        tv[4]  = '{1'b0, 1'b1,  3, 504, 1'b1, 1'b1, 1, 0};
        tv[5]  = '{1'b0, 1'b1,  3, 512, 1'b0, 1'b1, 1, 0};
        tv[6]  = '{1'b0, 1'b1,  3, 520, 1'b0, 1'b1, 1, 0};
        tv[7]  = '{1'b0, 1'b1,  9, 600, 1'b0, 1'b1, 1, 1};
        tv[8]  = '{1'b0, 1'b1,  9, 608, 1'b0, 1'b1, 1, 1};
        tv[9]  = '{1'b0, 1'b1, 10,   0, 1'b0, 1'b1, 1, 1};
        tv[10] = '{1'b0, 1'b1, 10, 496, 1'b0, 1'b1, 1, 1};
        tv[11] = '{1'b0, 1'b1, 10, 504, 1'b1, 1'b1, 2, 1};
        tv[12] = '{1'b0, 1'b1, 10, 400, 1'b0, 1'b1, 2, 2};
        tv[13] = '{1'b0, 1'b1, 11, 400, 1'b1, 1'b1, 3, 2};
        tv[14] = '{1'b0, 1'b1, 12, 600, 1'b1, 1'b1, 4, 2};
        tv[15] = '{1'b0, 1'b1, 12, 608, 1'b0, 1'b1, 4, 2};
        tv[16] = '{1'b0, 1'b0, 12, 616, 1'b0, 1'b0, 4, 2};

        off_v = 0;
        offset_ns = 30'd500; width_ns = 30'd0;
        for (int i = 0; i < 17; i++) begin
            reset = tv[i].rst; enable = tv[i].en;
            set_t(tv[i].s, tv[i].n);
            cyc();
            chk("tv_pps", pps_out, tv[i].pps);
            chk("tv_armed", armed, tv[i].arm);
            chk("tv_pulse_cnt", pulse_cnt, tv[i].pc);
            chk("tv_jump_cnt", jump_cnt, tv[i].jc);
        end

        // 100 ns pulse at the second boundary lasts 13 cycles
        do_reset();
        offset_ns = 30'd0; width_ns = 30'd100; enable = 1'b1;
        set_t(7, 999_999_968); cyc();
        for (int i = 0; i < 3; i++) begin adv(8); cyc(); end
        adv(8); cyc();
        for (int i = 0; i < 16; i++) begin
            chk("w100_pps", pps_out, (i < 13));
`ifdef PPS_GEN_TOD_EN
            chk("w100_tod_valid", tod_valid, (i == 0));
            chk("w100_tod_sec", tod_sec, 8);
`endif
            adv(8); cyc();
        end
        chk("w100_pulse_cnt", pulse_cnt, 1);

        // invalid offset suppresses pulses across three seconds, then recovery
        do_reset();
        offset_ns = 30'd1_000_000_000; width_ns = 30'd100; enable = 1'b1;
        set_t(20, 999_999_976); cyc();
        chk("cfg_err_set", cfg_err, 1);
        for (int s = 20; s < 23; s++) begin
            set_t(s, 999_999_984); cyc();
            adv(8); cyc();
            adv(8); cyc(); chk("cfg_roll_pps", pps_out, 0);
            adv(8); cyc(); chk("cfg_hold_armed", armed, 1);
        end
        chk("cfg_pulse_cnt", pulse_cnt, 0);
        offset_ns = 30'd0;
        adv(8); cyc();
        chk("cfg_clear", cfg_err, 0);
        chk("cfg_clear_pps", pps_out, 0);
        set_t(23, 999_999_992); cyc(); chk("cfg_wait_pps", pps_out, 0);
        adv(8); cyc();
        chk("cfg_rollover_pps", pps_out, 1);
        chk("cfg_rollover_cnt", pulse_cnt, 1);

        // enable drop and reset in the middle of an 800 ns pulse
        do_reset();
        offset_ns = 30'd0; width_ns = 30'd800; enable = 1'b1;
        set_t(30, 999_999_968);
        for (int i = 0; i < 4; i++) begin cyc(); adv(8); end
        cyc();
        for (int i = 0; i < 49; i++) begin adv(8); cyc(); end
        chk("mid_high", pps_out, 1);
        enable = 1'b0; adv(8); cyc();
        chk("mid_en_pps", pps_out, 0);
        chk("mid_en_cnt", pulse_cnt, 1);
        enable = 1'b1;
        set_t(31, 999_999_968);
        for (int i = 0; i < 4; i++) begin cyc(); adv(8); end
        cyc();
        for (int i = 0; i < 49; i++) begin adv(8); cyc(); end
        chk("mid2_high", pps_out, 1);
        chk("mid2_cnt", pulse_cnt, 2);
        reset = 1'b1; adv(8); cyc(); reset = 1'b0;
        chk("mid_rst_pps", pps_out, 0);
        chk("mid_rst_pcnt", pulse_cnt, 0);
        chk("mid_rst_jcnt", jump_cnt, 0);

        // retrigger inside a clamped maximum-width pulse
        do_reset();
        offset_ns = 30'd0; width_ns = 30'h3FFF_FFFF; enable = 1'b1;
        set_t(40, 999_999_968);
        for (int i = 0; i < 4; i++) begin cyc(); adv(8); end
        cyc();
        for (int i = 0; i < 20; i++) begin adv(8); cyc(); end
        set_t(42, 168); cyc();
        chk("retrig_pps", pps_out, 1);
        chk("retrig_cnt", pulse_cnt, 2);
        chk("retrig_jcnt", jump_cnt, 0);
        for (int i = 0; i < 200; i++) begin adv(8); cyc(); end
        chk("retrig_still_high", pps_out, 1);

        // randomized segments
        for (int seg = 0; seg < 16; seg++) begin
            int pick;
            enable = 1'b0; reset = 1'b0;
            cyc(); cyc();
            pick = $urandom_range(0, 5);
            case (pick)
                0: width_ns = 30'd0;
                1: width_ns = 30'd9;
                2: width_ns = 30'd100;
                3: width_ns = 30'(longint'($urandom_range(0, 2000)));
                4: width_ns = 30'd800;
                default: width_ns = 30'd64;
            endcase
            pick = $urandom_range(0, 4);
            case (pick)
                0: off_v = 0;
                1: off_v = 500;
                2: off_v = 999_999_990;
                3: off_v = NS + $urandom_range(0, 1000);
                default: off_v = $urandom_range(0, 999_999_999);
            endcase
            offset_ns = 30'(off_v);
            set_t(100 + seg * 10, (off_v < NS && off_v >= 100) ? off_v - 100 : 999_999_800);
            for (int i = 0; i < 250; i++) begin
                enable = ($urandom_range(0, 99) != 0);
                reset  = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 99) < 2) begin
                    off_v = $urandom_range(0, 999_999_999);
                    offset_ns = 30'(off_v);
                end
                rand_time();
                cyc();
            end
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pps_gen.md
Name: pps_gen

Overview:
- Time-driven pulse generator: the output end of the real-time clock's PPS interface.
- Consumes the running sec/nsec time from the rtclock block and emits a PPS pulse each time that time crosses a programmable phase offset within the second.
- Pulse width is programmable.
- Feeds board PPS outputs and downstream cores that use pps/pps2 as reference.

Parameters:
C_CLK_TO_NS_RATIO, 8, ns advanced per clk cycle; used to time the pulse width.
C_CNT_WIDTH, 32, width of pulse_cnt and jump_cnt.

Ports:
clk  in  1  core clock, same domain as sec/nsec source
reset  in  1  synchronous reset, active-high
enable  in  1  generator enable (level)
offset_ns  in  30  trigger phase within second, valid 0..999_999_999
width_ns  in  30  pulse width in ns
sec  in  48  current seconds from rtclock
nsec  in  30  current nanoseconds from rtclock
pps_out  out  1  generated PPS pulse
armed  out  1  high in ARMED or PULSE state
cfg_err  out  1  offset_ns >= 1_000_000_000 (registered)
pulse_cnt  out  C_CNT_WIDTH  pulses generated, wraps
jump_cnt  out  C_CNT_WIDTH  time discontinuities detected, wraps

Behaviour:
- Reset values: all outputs 0; state DISABLED; prev_sec/prev_nsec 0.
- sec/nsec are registered every cycle into prev_sec/prev_nsec. All comparisons use (prev, current).
- States:
  - DISABLED: enable=0 forces this state from any state. Exit to SYNC when enable=1.
  - SYNC: one cycle to capture a valid prev sample, then go to ARMED.
  - ARMED: wait for a crossing.
  - PULSE: pps_out high while the width counter runs.
- Crossing, with prev=(ps,pn) and current=(s,n):
  - same second: s==ps && pn<offset_ns && n>=offset_ns; or
  - rollover: s==ps+1 && (pn<offset_ns || n>=offset_ns).
- Jump: any other change, i.e. s not in {ps, ps+1}, or s==ps with n<pn.
  - On a jump: no pulse that cycle; jump_cnt+1; state returns to ARMED (a PULSE in progress is cut, pps_out 0 next cycle).
- Crossing detected in ARMED or PULSE:
  - next cycle pps_out=1 and pulse_cnt+1;
  - width accumulator cleared to C_CLK_TO_NS_RATIO.
  - A crossing during PULSE retriggers: the accumulator restarts and pps_out stays high.
- Pulse length: pps_out high for max(1, ceil(width_ns/C_CLK_TO_NS_RATIO)) cycles.
  - Accumulator adds C_CLK_TO_NS_RATIO per cycle; pulse ends in the cycle the accumulator reaches >= width_ns.
  - width_ns values above 999_999_999 are clamped to 999_999_999.
- Latency: one clk from the cycle the crossing appears on sec/nsec to pps_out rising.
- cfg_err=1: no crossings are evaluated; state held in ARMED; pps_out forced 0. Clearing cfg_err resumes normal operation with no spurious pulse.
- enable falling: pps_out=0 next cycle; counters hold.
- reset mid-pulse: all state and outputs return to reset values the following cycle.
- Stepping sec/nsec by exactly one second (s=ps+1, n=pn) counts as a crossing only if the rollover rule holds; it is not counted as a jump.

Optional Feature:
- PPS_GEN_TOD_EN defined: adds outputs tod_sec[47:0] and tod_valid.
  - tod_valid pulses for one cycle, coincident with each pps_out rising edge (retriggers included).
  - tod_sec = s if n>=offset_ns, else ps: the second in which the trigger point lies.
  - Reset: tod_sec=0, tod_valid=0.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- enable=1, offset_ns=0, width_ns=100; time steps (7,999_999_992)->(8,0) -> pps_out high 1 cycle later for 13 cycles; pulse_cnt=1; with TOD_EN, tod_sec=8 and tod_valid 1 cycle.
- offset_ns=500, width_ns=0; nsec 496->504, sec=3 constant -> pps_out high exactly 1 cycle; no pulse on the next cycles 504->512.
- Jump: sec 5->9 with nsec crossing offset -> no pulse, jump_cnt=1, armed=1; next normal crossing -> pulse, pulse_cnt+1.
- offset_ns=1_000_000_000 -> cfg_err=1 next cycle, no pulses over 3 simulated seconds; set offset_ns=0 -> first pulse at next rollover only.
- Mid-pulse (width_ns=800, cycle 50 of 100): enable->0 -> pps_out 0 next cycle. Repeat with reset=1 -> pps_out, pulse_cnt and jump_cnt all 0 next cycle.
- Retrigger: offset_ns=0, width_ns=999_999_999 clamp; time jumps forward so two crossings occur within one pulse -> pps_out stays high, pulse_cnt=2, pulse ends 125_000_000 cycles after second trigger.
